// File: rtl/mdio_master.sv
// mdio_master -- Clause-22 MDIO management-interface master.
//
// Serialises one 64-bit management frame per accepted command:
//   32 x '1' preamble, ST=01, OP (01 write / 10 read), PHYAD[4:0],
//   REGAD[4:0], TA, DATA[15:0], MSB first.
// Each bit lasts 2*CLK_DIV system clocks: MDC is low for the first
// CLK_DIV cycles and high for the second CLK_DIV cycles.
//
// Optional feature (macro MDIO_TA_CHECK_EN): on reads, the second
// turnaround bit is sampled. If it is 1, no PHY drove the line, and
// o_rsp_err is raised alongside o_rsp_valid. Without the macro,
// o_rsp_err is tied to 0.
//
// Command handshake: a command transfers in the cycle where
// i_cmd_valid && o_cmd_ready. o_cmd_ready is high only in IDLE, and
// i_cmd_valid is ignored in every other state. All command fields are
// captured on transfer, so the requester may change them freely
// afterwards.
//
// Ports:
//   i_sys_clk    system clock
//   i_nreset     asynchronous active-low reset
//   i_cmd_valid  command request
//   o_cmd_ready  command accepted when valid && ready
//   i_cmd_write  1 = write, 0 = read
//   i_phy_addr   PHY address [4:0]
//   i_reg_addr   register address [4:0]
//   i_wdata      write data [15:0]
//   o_rsp_valid  one-cycle completion pulse
//   o_rdata      read data [15:0], held until the next read completes
//   o_rsp_err    read turnaround error (valid with o_rsp_valid)
//   o_busy       frame in progress
//   o_mdc        management clock
//   o_mdio_o     MDIO drive value
//   o_mdio_oe    MDIO drive enable (tristate buffer lives at top level)
//   i_mdio_i     MDIO sampled value
//   o_dbg_state  current FSM state (debug observation)

module mdio_master #(
   parameter int CLK_DIV = 25  // sys clocks per MDC half-period, 2..255
) (
   input  logic        i_sys_clk,
   input  logic        i_nreset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_write,
   input  logic [4:0]  i_phy_addr,
   input  logic [4:0]  i_reg_addr,
   input  logic [15:0] i_wdata,
   output logic        o_rsp_valid,
   output logic [15:0] o_rdata,
   output logic        o_rsp_err,
   output logic        o_busy,
   output logic        o_mdc,
   output logic        o_mdio_o,
   output logic        o_mdio_oe,
   input  logic        i_mdio_i,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_HEADER   = 3'd2,
      S_TA       = 3'd3,
      S_DATA     = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t       state_q, state_d;
   logic [7:0]   div_cnt;     // cycle within the current MDC half
   logic [5:0]   bit_cnt;     // bit index within the frame, wraps 63 -> 0
   logic         mdc_q;
   logic         mdio_q;
   logic [62:0]  tail_q;      // frame bits still to be sent after the current one
   logic         wr_q;
   logic [15:0]  rd_shift;
   logic [15:0]  rdata_q;

   logic in_frame;
   logic accept;
   logic half_end;
   logic mdc_rise;
   logic bit_end;

   assign in_frame = (state_q == S_PREAMBLE) || (state_q == S_HEADER) ||
                     (state_q == S_TA)       || (state_q == S_DATA);
   assign accept   = (state_q == S_IDLE) && i_cmd_valid;
   assign half_end = in_frame && (div_cnt == DIV_LAST);
   // The edge ending the low half is the one that raises MDC: sample there.
   assign mdc_rise = half_end && !mdc_q;
   assign bit_end  = half_end && mdc_q;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge i_sys_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic. Phase changes happen only at bit ends.
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (i_cmd_valid)                   state_d = S_PREAMBLE;
         S_PREAMBLE: if (bit_end && bit_cnt == 6'd31)   state_d = S_HEADER;
         S_HEADER:   if (bit_end && bit_cnt == 6'd45)   state_d = S_TA;
         S_TA:       if (bit_end && bit_cnt == 6'd47)   state_d = S_DATA;
         S_DATA:     if (bit_end && bit_cnt == 6'd63)   state_d = S_DONE;
         S_DONE:                                        state_d = S_IDLE;
         default:                                       state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Divider, bit counter and serial output
   // ---------------------------------------------------------------
   always_ff @(posedge i_sys_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         mdc_q   <= 1'b0;
         mdio_q  <= 1'b1;
         tail_q  <= '0;
         wr_q    <= 1'b0;
      end else if (accept) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         mdc_q   <= 1'b0;
         mdio_q  <= 1'b1;  // first preamble bit goes out right away
         wr_q    <= i_cmd_write;
         // Read TA/DATA bits are placeholders; the line is released then.
         tail_q  <= {31'h7FFF_FFFF, 2'b01,
                     (i_cmd_write ? 2'b01 : 2'b10),
                     i_phy_addr, i_reg_addr,
                     (i_cmd_write ? 2'b10 : 2'b11),
                     (i_cmd_write ? i_wdata : 16'hFFFF)};
      end else if (in_frame) begin
         if (half_end) begin
            div_cnt <= '0;
            mdc_q   <= ~mdc_q;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (bit_end) begin
            bit_cnt <= bit_cnt + 6'd1;
            // After the last bit MDIO simply holds; the next accept reloads it.
            if (bit_cnt != 6'd63) begin
               mdio_q <= tail_q[62];
               tail_q <= {tail_q[61:0], 1'b0};
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Read data: shift into a private register, publish at frame end so
   // o_rdata only changes when a read completes.
   // ---------------------------------------------------------------
   always_ff @(posedge i_sys_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         rd_shift <= '0;
         rdata_q  <= '0;
      end else begin
         if (mdc_rise && state_q == S_DATA && !wr_q) begin
            rd_shift <= {rd_shift[14:0], i_mdio_i};
         end
         if (bit_end && state_q == S_DATA && bit_cnt == 6'd63 && !wr_q) begin
            rdata_q <= rd_shift;
         end
      end
   end

`ifdef MDIO_TA_CHECK_EN
   logic ta_bad_q;

   // A PHY pulls the second TA bit low; a 1 means nobody answered.
   always_ff @(posedge i_sys_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         ta_bad_q <= 1'b0;
      end else if (accept) begin
         ta_bad_q <= 1'b0;
      end else if (mdc_rise && state_q == S_TA && bit_cnt == 6'd47 && !wr_q) begin
         ta_bad_q <= i_mdio_i;
      end
   end

   assign o_rsp_err = (state_q == S_DONE) && ta_bad_q;
`else
   assign o_rsp_err = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign o_cmd_ready = (state_q == S_IDLE);
   assign o_busy      = (state_q != S_IDLE);
   assign o_rsp_valid = (state_q == S_DONE);
   assign o_rdata     = rdata_q;
   assign o_mdc       = mdc_q;
   assign o_mdio_o    = mdio_q;
   // Reads release the line from TA onward so the PHY can drive it.
   assign o_mdio_oe   = (state_q == S_PREAMBLE) || (state_q == S_HEADER) ||
                        (wr_q && ((state_q == S_TA) || (state_q == S_DATA)));
   assign o_dbg_state = state_q;

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: i_sys_clk cycles per MDC half-period; legal range 2..255.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: i_sys_clk, i_nreset.
REQ-003 SHALL have ports:
- i_sys_clk  in  1  system clock
- i_nreset  in  1  async active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_write  in  1  1=write, 0=read
- i_phy_addr  in  5  PHY address
- i_reg_addr  in  5  register address
- i_wdata  in  16  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rdata  out  16  read data
- o_rsp_err  out  1  read turnaround error
- o_busy  out  1  frame in progress
- o_mdc  out  1  management clock
- o_mdio_o  out  1  MDIO drive value
- o_mdio_oe  out  1  MDIO drive enable (tristated at top level)
- i_mdio_i  in  1  MDIO sampled value

Function
REQ-004 SHALL emit Clause-22 frames of 64 bits, MSB first: 32 ones preamble, ST=01, OP (01 write, 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-005 SHALL size each bit at 2*CLK_DIV cycles: o_mdc low for the first CLK_DIV cycles, high for the second CLK_DIV cycles.
REQ-006 SHALL update o_mdio_o only in the first cycle of the MDC-low half of each bit.
REQ-007 SHALL sample i_mdio_i in the cycle in which o_mdc rises.
REQ-008 SHALL implement states IDLE -> PREAMBLE (32 bits) -> HEADER (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
REQ-009 SHALL assert o_cmd_ready only in IDLE and capture all command fields on acceptance; i_cmd_valid is ignored outside IDLE.
REQ-010 SHALL assert o_busy in every state except IDLE.
REQ-011 SHALL drive o_mdio_oe=1 from PREAMBLE through the end of DATA for writes; writes drive TA=10.
REQ-012 SHALL drive o_mdio_oe=1 for reads through the end of HEADER only, and 0 during TA and DATA.
REQ-013 SHALL shift sampled read bits into o_rdata MSB first during DATA; o_rdata holds its value until the next read completes and is unchanged by writes.
REQ-014 SHALL spend exactly one cycle in DONE, pulsing o_rsp_valid, with o_cmd_ready=1 in the following cycle.
REQ-015 SHALL produce o_rsp_valid exactly 128*CLK_DIV+1 cycles after the accept cycle.
REQ-016 SHALL hold o_mdc=0 and o_mdio_oe=0 in IDLE and DONE.
REQ-017 SHALL cover the sys-clock divider and 64-bit frame with counters that wrap to zero at bit boundaries, with no gap cycles between bits.

Reset
REQ-018 SHALL, while i_nreset=0 (asynchronously), force: state IDLE, o_cmd_ready=1, o_busy=0, o_rsp_valid=0, o_rsp_err=0, o_rdata=0, o_mdc=0, o_mdio_o=1, o_mdio_oe=0.
REQ-019 SHALL, on reset assertion mid-frame, abort the frame with no o_rsp_valid; the first command after release starts a full frame.

Configuration
REQ-020 SHALL, with macro MDIO_TA_CHECK_EN defined, sample the second TA bit of reads and set o_rsp_err=1 with o_rsp_valid if it is 1 (PHY absent); o_rdata is still captured; o_rsp_err=0 for writes and good reads.
REQ-021 SHALL, without MDIO_TA_CHECK_EN, tie o_rsp_err to 0 and omit the TA sample logic.

Verification (CLK_DIV=4)
REQ-022 SHALL cover: write phy=0x10, reg=25, data=0x1234 -> serial 32x1, 01, 01, 10000, 11001, 10, 0001001000110100; oe=1 throughout; o_rsp_valid 513 cycles after accept.
REQ-023 SHALL cover: read phy=0x01, reg=0x02, PHY model drives TA=0 and 0xBEEF -> oe=0 from TA onward, o_rdata=0xBEEF, o_rsp_err=0.
REQ-024 SHALL cover: read with i_mdio_i held 1 (no PHY) -> o_rdata=0xFFFF, o_rsp_err=1 with macro, 0 without.
REQ-025 SHALL cover: i_cmd_valid held high with two queued commands -> second accepted the cycle after o_rsp_valid; toggling command fields mid-frame does not affect the serial stream.
REQ-026 SHALL cover: i_nreset pulsed low during bit 40 -> o_mdc=0, oe=0 immediately, no o_rsp_valid, o_cmd_ready=1 after release.
